// File: rtl/pmod_pkg.sv
// Shared types and timing constants for the PMOD button conditioning path.
package pmod_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    localparam int CLK_HZ      = 12_000_000;
    localparam int DEBOUNCE_MS = 10;

    // 10 ms worth of clk cycles at the board clock.
    localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_ch.sv
// Single button channel: two-flop synchroniser, debounce FSM with stability counter,
// registered debounced level and one-cycle press/release strobes.
//
// state        | meaning
// -------------+------------------------------------------------------------
// RELEASED     | stable high (button up), waiting for a low sample
// PRESS_PEND   | seeing low, counting consecutive low samples
// PRESSED      | stable low (button down), waiting for a high sample
// RELEASE_PEND | seeing high, counting consecutive high samples
module debounce_ch
    import pmod_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_db,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_press;
    logic             r_release;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_db_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_db      <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= i_pin;
            r_s2      <= r_s1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_db      <= w_db_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_db_nxt      = r_db;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            RELEASED: begin
                if (!r_s2) begin
                    w_state_nxt = PRESS_PEND;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_PEND: begin
                if (r_s2) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_db_nxt    = 1'b0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (r_s2) begin
                    w_state_nxt = RELEASE_PEND;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_PEND: begin
                if (!r_s2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TC) begin
                    w_state_nxt   = RELEASED;
                    w_cnt_nxt     = '0;
                    w_db_nxt      = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_db      = r_db;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/pmod_debounce.sv
// Conditions WIDTH raw active-low PMOD button lines into clean levels (same polarity)
// plus per-channel press/release strobes; channels are fully independent.
module pmod_debounce
    import pmod_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pmod,
    output logic [WIDTH-1:0] o_db_pmod,
    output logic [WIDTH-1:0] o_press,
    output logic [WIDTH-1:0] o_release
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_release;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_pin     (i_pmod[g]),
            .o_db      (w_db[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign o_db_pmod = w_db;
    assign o_press   = w_press;
    assign o_release = w_release;

endmodule
